// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the default geometry, the address-split widths derived from it,
// the controller state encoding and a saturating counter helper.
package icache_pkg;

  localparam int DEF_ADD_WIDTH      = 17;
  localparam int DEF_LINES          = 64;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Address split widths for the default geometry
  localparam int OFF_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADD_WIDTH - OFF_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data array: one 32-bit word per (line, word offset).
// Ports:
//   clk      in   write clock
//   i_we     in   write enable
//   i_waddr  in   write word address {index, offset}
//   i_wdata  in   write data
//   i_raddr  in   read word address {index, offset}
//   o_rdata  out  read data (combinational read)
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int AW = IDX_W + OFF_W
)(
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  // Synchronous write port, filled one word per refill response
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read keeps hit data available within the request cycle
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the fetch stage and a
// word-wide backing memory. Hits deliver one cycle after the request; misses
// stall fetch, refill the whole line word 0 first, then deliver the word.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_req, cpu_addr          fetch request and byte address
//   cpu_stall                  cache busy, request not accepted
//   cpu_rvalid, cpu_rdata      one-cycle data pulse per accepted request
//   flush                      invalidate every line
//   mem_req, mem_addr, mem_gnt backing read request handshake
//   mem_rvalid, mem_rdata      in-order backing responses
//   miss_count                 saturating miss counter
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADD_WIDTH      = DEF_ADD_WIDTH,
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] miss_count
);

  localparam int C_OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int C_IDX_W  = $clog2(LINES);
  localparam int C_TAG_W  = ADD_WIDTH - C_OFF_W - C_IDX_W - 2;
  localparam int C_RAM_AW = C_IDX_W + C_OFF_W;
  localparam logic [C_OFF_W-1:0] C_LAST = C_OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [C_OFF_W-1:0] C_ONE  = C_OFF_W'(1);

  state_t               r_state;
  logic [LINES-1:0]     r_valid;
  logic [C_TAG_W-1:0]   r_tag [LINES];
  logic [C_TAG_W-1:0]   r_lat_tag;
  logic [C_IDX_W-1:0]   r_lat_idx;
  logic [C_OFF_W-1:0]   r_lat_off;
  logic [C_OFF_W-1:0]   r_iss_cnt;
  logic [C_OFF_W-1:0]   r_rx_cnt;
  logic                 r_flush_pend;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_mem_req;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_miss_count;

  logic [C_OFF_W-1:0]   w_off;
  logic [C_IDX_W-1:0]   w_idx;
  logic [C_TAG_W-1:0]   w_tag;
  logic                 w_hit;
  logic                 w_ram_we;
  logic                 w_last_rx;
  logic [C_RAM_AW-1:0]  w_raddr;
  logic [C_RAM_AW-1:0]  w_waddr;
  logic [31:0]          w_ram_rdata;
  logic [31:0]          w_line_base;
  logic                 w_unused_addr;

  // Address split; bits above ADD_WIDTH alias onto the same lines
  assign w_off = cpu_addr[2 +: C_OFF_W];
  assign w_idx = cpu_addr[C_OFF_W + 2 +: C_IDX_W];
  assign w_tag = cpu_addr[ADD_WIDTH-1 : C_OFF_W + C_IDX_W + 2];
  assign w_unused_addr = ^{cpu_addr[31:ADD_WIDTH], cpu_addr[1:0]};

  // Line-aligned backing address, truncated to the significant bits
  assign w_line_base = {{(32 - ADD_WIDTH){1'b0}}, w_tag, w_idx, {(C_OFF_W + 2){1'b0}}};

  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ram_we  = (r_state == REFILL) && mem_rvalid;
  assign w_last_rx = w_ram_we && (r_rx_cnt == C_LAST);
  assign w_waddr   = {r_lat_idx, r_rx_cnt};

  // Read port follows the live request when idle, else the latched miss word
  always_comb begin
    w_raddr = {r_lat_idx, r_lat_off};
    if (r_state == IDLE) begin
      w_raddr = {w_idx, w_off};
    end else begin
      w_raddr = {r_lat_idx, r_lat_off};
    end
  end

  icache_data_ram #(
    .AW (C_RAM_AW)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_waddr),
    .i_wdata (mem_rdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  // Tag store: written once per refill; qualified by r_valid so no reset needed
  always_ff @(posedge clk) begin
    if (w_last_rx) begin
      r_tag[r_lat_idx] <= r_lat_tag;
    end
  end

  // Controller: lookup, refill sequencing, delivery, flush and miss counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_lat_tag    <= '0;
      r_lat_idx    <= '0;
      r_lat_off    <= '0;
      r_iss_cnt    <= '0;
      r_rx_cnt     <= '0;
      r_flush_pend <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid <= 1'b0;
          // Lookup above used pre-flush valids; clearing lands at this edge
          if (flush) begin
            r_valid <= '0;
          end
          if (cpu_req) begin
            if (w_hit) begin
              r_rvalid <= 1'b1;
              r_rdata  <= w_ram_rdata;
            end else begin
              r_lat_tag    <= w_tag;
              r_lat_idx    <= w_idx;
              r_lat_off    <= w_off;
              r_iss_cnt    <= '0;
              r_rx_cnt     <= '0;
              r_flush_pend <= 1'b0;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= w_line_base;
              r_miss_count <= sat_inc32(r_miss_count);
              r_state      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (r_mem_req && mem_gnt) begin
            r_iss_cnt <= r_iss_cnt + C_ONE;
            if (r_iss_cnt == C_LAST) begin
              r_mem_req <= 1'b0;
            end else begin
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
          if (mem_rvalid) begin
            r_rx_cnt <= r_rx_cnt + C_ONE;
            if (r_rx_cnt == C_LAST) begin
              // A flush seen at any point of the refill leaves the line invalid
              if (!(r_flush_pend || flush)) begin
                r_valid[r_lat_idx] <= 1'b1;
              end
              r_rvalid <= 1'b1;
              // The requested word may be the one arriving right now
              r_rdata  <= (r_lat_off == r_rx_cnt) ? mem_rdata : w_ram_rdata;
              r_state  <= RESPOND;
            end
          end
        end
        RESPOND: begin
          r_rvalid <= 1'b0;
          if (r_flush_pend || flush) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_rvalid  <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall  = (r_state != IDLE);
  assign cpu_rvalid = r_rvalid;
  assign cpu_rdata  = r_rdata;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: a bench-side backing memory with fixed
// response latency and optional grant hold-off, a line-level cache model,
// a per-cycle compare process and directed scenarios with literal values.
module tb_icache_dm;

  localparam int LINES = 64;
  localparam int LAT   = 2;
  localparam logic [31:0] AMASK = 32'h0001_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic        flush = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] miss_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  icache_dm dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory contents: 0x40 -> 0xA0, 0x44 -> 0xA1, ...
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hA0 + (a >> 2) - 32'h10;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- backing memory ----------------
  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;
  rsp_t        rq[$];
  logic [31:0] glog[$];
  logic [31:0] hold_addr = 32'd0;
  int          hold_left = 0;

  initial begin : memory
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        rq.delete();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
      end else begin
        if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
          mem_rvalid = 1'b1;
          mem_rdata = rq[0].d;
          void'(rq.pop_front());
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata = 32'd0;
        end
        if (mem_req) begin
          if (hold_left > 0 && mem_addr == hold_addr) begin
            mem_gnt = 1'b0;
            hold_left--;
            chk("hold_stall", {31'd0, cpu_stall}, 32'd1);
          end else begin
            mem_gnt = 1'b1;
            r.d = mem_data(mem_addr);
            r.due = cyc + 1 + LAT;
            rq.push_back(r);
            glog.push_back(mem_addr);
          end
        end else begin
          mem_gnt = 1'b0;
        end
      end
    end
  end

  // ---------------- cache model ----------------
  // 0: accepting, 1: waiting for line words, 2: delivering the missed word
  int          m_phase = 0;
  logic [31:0] m_line [LINES];
  bit          m_valid [LINES];
  logic [31:0] m_miss = 32'd0;
  logic [31:0] m_last = 32'd0;
  logic [31:0] exp_d = 32'd0;
  bit          exp_rv = 1'b0;
  bit          m_pend = 1'b0;
  int          m_left = 0;
  logic [31:0] m_a, m_ln, m_req_a, m_req_ln;

  task automatic m_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0;
        m_clear();
        m_miss = 32'd0;
        m_last = 32'd0;
        exp_rv = 1'b0;
        m_pend = 1'b0;
      end else begin
        exp_rv = 1'b0;
        if (m_phase == 0) begin
          if (cpu_req) begin
            m_a = cpu_addr & AMASK;
            m_ln = m_a >> 4;
            if (m_valid[m_ln % LINES] && m_line[m_ln % LINES] == m_ln) begin
              exp_rv = 1'b1;
              exp_d = mem_data(m_a);
            end else begin
              if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
              m_req_a = m_a;
              m_req_ln = m_ln;
              m_left = 4;
              m_pend = 1'b0;
              m_phase = 1;
            end
          end
          if (flush) m_clear();
        end else if (m_phase == 1) begin
          if (flush) m_pend = 1'b1;
          if (mem_rvalid) begin
            m_left--;
            if (m_left == 0) begin
              if (!m_pend) begin
                m_valid[m_req_ln % LINES] = 1'b1;
                m_line[m_req_ln % LINES] = m_req_ln;
              end
              exp_rv = 1'b1;
              exp_d = mem_data(m_req_a);
              m_phase = 2;
            end
          end
        end else begin
          if (flush || m_pend) m_clear();
          m_pend = 1'b0;
          m_phase = 0;
        end
        if (exp_rv) m_last = exp_d;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("stall", {31'd0, cpu_stall}, {31'd0, (m_phase != 0)});
        chk("rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_rv});
        chk("rdata", cpu_rdata, m_last);
        chk("miss_count", miss_count, m_miss);
        if (m_phase != 1) chk("mem_req_quiet", {31'd0, mem_req}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (cpu_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, {31'd0, cpu_stall}, 32'd0);
  endtask

  task automatic wait_rvalid(input logic [31:0] exp, input string nm);
    int n;
    n = 0;
    while (!cpu_rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_rvalid"}, {31'd0, cpu_rvalid}, 32'd1);
    chk({nm, "_rdata"}, cpu_rdata, exp);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] exp, input string nm);
    wait_idle(nm);
    cpu_req = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_req = 1'b0;
    wait_rvalid(exp, nm);
  endtask

  task automatic chk_line_log(input logic [31:0] base, input string nm);
    chk({nm, "_ngrants"}, glog.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < glog.size()) chk({nm, "_addr"}, glog[k], base + 32'(4 * k));
    end
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Cold miss on 0x40
    glog.delete();
    do_req(32'h40, 32'hA0, "cold");
    chk_line_log(32'h40, "cold");
    chk("cold_miss", miss_count, 32'd1);

    // Back-to-back hits on the rest of the line
    wait_idle("hits");
    cpu_req = 1'b1;
    cpu_addr = 32'h44;
    @(negedge clk);
    chk("hit0_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("hit0_rdata", cpu_rdata, 32'hA1);
    cpu_addr = 32'h48;
    @(negedge clk);
    chk("hit1_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("hit1_rdata", cpu_rdata, 32'hA2);
    cpu_addr = 32'h4C;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("hit2_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("hit2_rdata", cpu_rdata, 32'hA3);
    chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
    chk("hit_miss", miss_count, 32'd1);

    // Conflict on the same index, then an aliased address
    do_req(32'h440, 32'h1A0, "conflict");
    chk("conflict_miss", miss_count, 32'd2);
    glog.delete();
    do_req(32'h0002_0040, 32'hA0, "alias");
    chk("alias_miss", miss_count, 32'd3);
    chk_line_log(32'h40, "alias");

    // Idle flush, then refill with grant hold-off on the second word
    do_req(32'h44, 32'hA1, "prehit");
    chk("prehit_miss", miss_count, 32'd3);
    wait_idle("flush_idle");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    glog.delete();
    hold_addr = 32'h44;
    hold_left = 3;
    do_req(32'h48, 32'hA2, "postflush");
    chk("postflush_miss", miss_count, 32'd4);
    chk("hold_used", hold_left, 32'd0);
    chk_line_log(32'h40, "bp");
    do_req(32'h40, 32'hA0, "bp_w0");
    do_req(32'h44, 32'hA1, "bp_w1");
    do_req(32'h4C, 32'hA3, "bp_w3");
    chk("bp_miss", miss_count, 32'd4);

    // Flush during refill: word delivered, line not retained
    wait_idle("flush_refill");
    cpu_req = 1'b1;
    cpu_addr = 32'h80;
    @(negedge clk);
    cpu_req = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_rvalid(32'hB0, "flush_refill");
    chk("flush_refill_miss", miss_count, 32'd5);
    do_req(32'h80, 32'hB0, "refetch");
    chk("refetch_miss", miss_count, 32'd6);
    do_req(32'h84, 32'hB1, "refetch_hit");
    chk("refetch_hit_miss", miss_count, 32'd6);

    // Asynchronous reset in the middle of a refill
    wait_idle("areset");
    cpu_req = 1'b1;
    cpu_addr = 32'hC0;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    chk("pre_reset_stall", {31'd0, cpu_stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("areset_stall", {31'd0, cpu_stall}, 32'd0);
    chk("areset_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("areset_miss", miss_count, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(32'hC0, 32'hC0, "post_reset");
    chk("post_reset_miss", miss_count, 32'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
